ni_dma_tx: RTL
==============

// Module: ni_dma_tx
// PURPOSE
//  Network-interface transmit DMA on the DUT side of the TCD command interface. Consumes one
//  command (cmd_in, addr_in, nbytes_in) and reads nbytes_in bytes from local memory starting at
//  word address addr_in. Slices each memory word into flits, MS flit first, and streams them to
//  the router local port with a valid/ready handshake. Reports progress on status_out.
// PARAMETERS
//  MEMORY_BUS_WIDTH  32  memory word width in bits; multiple of FLIT_WIDTH, >= 8
//  FLIT_WIDTH        16  router flit width in bits; multiple of 8
//  Derived: AW = MEMORY_BUS_WIDTH-2, FPW = MEMORY_BUS_WIDTH/FLIT_WIDTH, FB = FLIT_WIDTH/8
// PORTS
//  clock       in   1      single clock, all logic on rising edge
//  reset       in   1      asynchronous, active-low reset
//  cmd_in      in   1      one-cycle start pulse, sampled with addr_in/nbytes_in
//  addr_in     in   AW     start word address
//  nbytes_in   in   AW     transfer length in bytes
//  status_out  out  5      [0] busy [1] done [2] len_err [3] overrun [4] zero_len
//  mem_rd_en   out  1      memory read strobe; data returned exactly 1 cycle later
//  mem_addr    out  AW     memory word address
//  mem_data    in   MEMORY_BUS_WIDTH   read data, valid the cycle after mem_rd_en
//  tx_data     out  FLIT_WIDTH         flit to router
//  tx_valid    out  1      flit valid
//  tx_ready    in   1      router accepts flit when tx_valid && tx_ready
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; status bits cleared. Reset mid-transfer aborts
//   immediately, with no further reads or flits. The held word is discarded.
//  FSM: IDLE -> FETCH -> WAIT -> SEND -> (FETCH | IDLE).
//   IDLE: when cmd_in=1, latch addr/nbytes and clear done/len_err/zero_len.
//    nbytes_in=0 -> set done and zero_len, stay IDLE, no reads.
//    nbytes_in % FB != 0 -> set len_err, stay IDLE, no reads.
//    Otherwise flits_left = nbytes_in/FB, busy=1, go to FETCH.
//   FETCH: mem_rd_en=1 for exactly one cycle with mem_addr=cur_addr, then go to WAIT.
//   WAIT: capture mem_data into word register. slice = min(FPW, flits_left). Go to SEND.
//   SEND: tx_valid=1. tx_data = word[MBW-1-k*FW -: FW] for slice index k.
//    Slice k advances only when tx_ready=1; data and valid stay stable while tx_ready=0.
//    Each accepted flit decrements flits_left.
//    On the last slice of the word:
//     flits_left reaches 0 -> busy=0, done=1, go to IDLE. tx_valid drops the next cycle.
//     otherwise cur_addr += 1 (wraps mod 2^AW) and go to FETCH.
//  Latency: cmd_in in cycle 0 -> mem_rd_en in cycle 1 -> first tx_valid in cycle 3.
//   Each extra word costs 2 bubble cycles (FETCH + WAIT).
//  Partial last word: only the remaining MS slices are sent; the lower slices are dropped.
//  Status behaviour:
//   done, len_err and zero_len are sticky until the next accepted cmd_in.
//   busy mirrors FSM != IDLE.
//   overrun is set when cmd_in=1 while busy. That command is ignored and the transfer in
//    flight is unaffected. overrun clears only on reset.
//   cmd_in in the same cycle that the last flit is accepted counts as busy -> overrun.
//  Widths: flits_left is AW bits; nbytes_in/FB never overflows. mem_addr has no carry-out.
// STRUCTURE
//  Package ni_pkg:
//   typedef enum logic[2:0] {IDLE, FETCH, WAIT, SEND} ni_tx_state_t
//   localparams ST_BUSY=0, ST_DONE=1, ST_LENERR=2, ST_OVERRUN=3, ST_ZERO=4
//  Sub-module ni_word_serializer:
//   Holds one word and a slice count. Emits MS-first flits with valid/ready. Signals last
//    accepted flit.
//   The top level owns the FSM, address and length counters, and status.
// TESTING (MEMORY_BUS_WIDTH=32, FLIT_WIDTH=16)
//  1. cmd addr=0x10 nbytes=8; mem[0x10]=0xAAAABBBB, mem[0x11]=0xCCCCDDDD, tx_ready=1 ->
//     reads 0x10 and 0x11; flits AAAA, BBBB, CCCC, DDDD; first valid at cycle 3; done=1, busy=0.
//  2. nbytes=6 from 0x20; mem[0x21]=0x12345678 -> 3 flits, the last is 0x1234; 0x5678 is never sent.
//  3. nbytes=5 -> status=5'b00100 next cycle, mem_rd_en never asserted.
//     nbytes=0 -> status=5'b10010.
//  4. Backpressure: tx_ready=0 for 3 cycles on flit 2 -> tx_data held at BBBB, tx_valid held 1.
//     Total flits remain 4 and in order.
//  5. Second cmd while busy -> overrun=1; the first transfer completes unchanged.
//     A new cmd after done starts normally and keeps overrun=1.
//  6. addr=0x3FFFFFFF nbytes=8 -> reads 0x3FFFFFFF then 0x0.
//     reset low during SEND -> all outputs 0 asynchronously; a later cmd runs cleanly.

Source files
------------

// File: rtl/ni_pkg.sv
// Shared types and status-bit positions for the NI transmit DMA.
package ni_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND} ni_tx_state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_LENERR  = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_ZERO    = 4;

endpackage

// File: rtl/ni_word_serializer.sv
// Holds one memory word and streams its upper nslice flits, MS first, over valid/ready.
module ni_word_serializer
    import ni_pkg::*;
#(
    parameter  int MBW = 32,
    parameter  int FW  = 16,
    localparam int FPW = MBW / FW,
    localparam int CW  = $clog2(FPW + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load_i,
    input  logic [MBW-1:0] word_i,
    input  logic [CW-1:0]  nslice_i,
    input  logic           ready_i,
    output logic [FW-1:0]  data_o,
    output logic           valid_o,
    output logic           last_o
);

    logic [MBW-1:0] word_q;
    logic [CW-1:0]  nslice_q, idx_q;
    logic           valid_q;
    logic           accept;

    assign accept  = valid_q && ready_i;
    assign last_o  = accept && (idx_q == nslice_q - 1'b1);
    assign valid_o = valid_q;

    // Output is forced to zero when idle so a stale word never shows on the bus.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < FPW; k++)
            if (valid_q && idx_q == CW'(k))
                data_o = word_q[MBW-1-k*FW -: FW];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q   <= '0;
            nslice_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            word_q   <= word_i;
            nslice_q <= nslice_i;
            idx_q    <= '0;
            valid_q  <= 1'b1;
        end else if (accept) begin
            if (last_o) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_dma_tx.sv
// Transmit DMA: fetches words from local memory and streams them as flits to the router.
module ni_dma_tx
    import ni_pkg::*;
#(
    parameter  int MEMORY_BUS_WIDTH = 32,
    parameter  int FLIT_WIDTH       = 16,
    localparam int AW               = MEMORY_BUS_WIDTH - 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cmd_in,
    input  logic [AW-1:0]               addr_in,
    input  logic [AW-1:0]               nbytes_in,
    output logic [4:0]                  status_out,
    output logic                        mem_rd_en,
    output logic [AW-1:0]               mem_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data,
    output logic [FLIT_WIDTH-1:0]       tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready
);

    localparam int FPW = MEMORY_BUS_WIDTH / FLIT_WIDTH;
    localparam int FB  = FLIT_WIDTH / 8;
    localparam int CW  = $clog2(FPW + 1);

    ni_tx_state_t  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, left_q, left_d;
    logic          done_q, done_d, lerr_q, lerr_d, zero_q, zero_d, ovr_q, ovr_d;
    logic          busy, ld, last;
    logic [CW-1:0] nslice;

    assign busy   = (state_q != IDLE);
    assign nslice = (left_q >= AW'(FPW)) ? CW'(FPW) : left_q[CW-1:0];

    ni_word_serializer #(.MBW(MEMORY_BUS_WIDTH), .FW(FLIT_WIDTH)) u_ser (
        .clock    (clock),
        .reset    (reset),
        .load_i   (ld),
        .word_i   (mem_data),
        .nslice_i (nslice),
        .ready_i  (tx_ready),
        .data_o   (tx_data),
        .valid_o  (tx_valid),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        done_d  = done_q;
        lerr_d  = lerr_q;
        zero_d  = zero_q;
        ld      = 1'b0;
        // A command arriving while a transfer is in flight is dropped but remembered.
        ovr_d   = ovr_q | (cmd_in & busy);
        case (state_q)
            IDLE: if (cmd_in) begin
                done_d = 1'b0;
                lerr_d = 1'b0;
                zero_d = 1'b0;
                addr_d = addr_in;
                if (nbytes_in == '0) begin
                    done_d = 1'b1;
                    zero_d = 1'b1;
                end else if ((nbytes_in % AW'(FB)) != '0) begin
                    lerr_d = 1'b1;
                end else begin
                    left_d  = nbytes_in / AW'(FB);
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                ld      = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (tx_valid && tx_ready)
                    left_d = left_q - 1'b1;
                if (last) begin
                    if (left_q == AW'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
            zero_q  <= zero_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = mem_rd_en ? addr_q : '0;

    always_comb begin
        status_out             = '0;
        status_out[ST_BUSY]    = busy;
        status_out[ST_DONE]    = done_q;
        status_out[ST_LENERR]  = lerr_q;
        status_out[ST_OVERRUN] = ovr_q;
        status_out[ST_ZERO]    = zero_q;
    end

endmodule
